// File: rtl/counter_mod_rev_if.sv
// Control and status bundle for counter_mod_rev.
// The master drives the count controls; the slave (the counter) returns the count and flags.
interface counter_mod_rev_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             s;
  logic             sat;
  logic             Load;
  logic [WIDTH-1:0] PData;
  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] cnt;
  logic             rc;
  logic             zero;

  modport master (
    output en, s, sat, Load, PData, lim,
    input  cnt, rc, zero
  );

  modport slave (
    input  en, s, sat, Load, PData, lim,
    output cnt, rc, zero
  );
endinterface

// File: rtl/counter_mod_rev.sv
// Up/down counter over 0..lim with wrap or saturate at the bounds, parallel load,
// and a registered terminal-count pulse.
module counter_mod_rev #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  counter_mod_rev_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             rc_q, rc_d;

  // The +1 step only happens below lim and the -1 step only above 0, so no
  // arithmetic path can overflow; the bound cases are handled explicitly.
  always_comb begin
    cnt_d = cnt_q;
    rc_d  = 1'b0;
    if (bus.Load) begin
      cnt_d = bus.PData;
    end else if (bus.en) begin
      if (bus.s) begin
        if (cnt_q < bus.lim) begin
          cnt_d = cnt_q + ONE;
        end else begin
          cnt_d = bus.sat ? bus.lim : '0;
          rc_d  = 1'b1;
        end
      end else begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          cnt_d = bus.sat ? '0 : bus.lim;
          rc_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RESET_VAL;
      rc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rc_q  <= rc_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.rc   = rc_q;
  assign bus.zero = (cnt_q == '0);

endmodule
